button_event: RTL and testbench
===============================

BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter LONG_MS, default 1000, hold time in ms that qualifies a long press.
REQ-003 The block SHALL have parameter REPEAT_MS, default 200, auto-repeat period in ms while long-held.
REQ-004 The block SHALL derive LONG_CYCLES = CLK_FREQ*LONG_MS/1000 and REPEAT_CYCLES = CLK_FREQ*REPEAT_MS/1000; the legal range is LONG_CYCLES >= 2 and REPEAT_CYCLES >= 1.
REQ-005 The block SHALL have port clk, input, 1 bit, clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit, reset, asynchronous, active-low.
REQ-007 The block SHALL have port btn, input, 1 bit, debounced button level, active-high, synchronous to clk.
REQ-008 The block SHALL have port press_pulse, output, 1 bit, one-cycle pulse on press.
REQ-009 The block SHALL have port release_pulse, output, 1 bit, one-cycle pulse on release.
REQ-010 The block SHALL have port short_press, output, 1 bit, one-cycle pulse on release before the long threshold.
REQ-011 The block SHALL have port long_press, output, 1 bit, one-cycle pulse when the long threshold is reached.
REQ-012 The block SHALL have port repeat_pulse, output, 1 bit, one-cycle auto-repeat pulse.
REQ-013 The block SHALL have port held, output, 1 bit, level, high while the block is in LONG state.

Function
REQ-014 All outputs SHALL be registered; btn_q SHALL hold the previous sample of btn.
REQ-015 The state machine SHALL have states IDLE, PRESSED and LONG.
REQ-016 In IDLE, when btn=1 and btn_q=0 are sampled at edge k, the block SHALL set press_pulse=1 for one cycle after edge k, clear the hold counter, and enter PRESSED.
REQ-017 In PRESSED, the hold counter SHALL increment once per cycle, and its width SHALL be $clog2(LONG_CYCLES)+1 bits.
REQ-018 In PRESSED, when btn=0 is sampled at edge k+n with n <= LONG_CYCLES, the block SHALL pulse release_pulse and short_press together after that edge and enter IDLE.
REQ-019 In PRESSED, when btn=1 is still sampled at edge k+LONG_CYCLES, the block SHALL pulse long_press after that edge, set held=1, clear the repeat counter, and enter LONG.
REQ-020 A release sampled exactly at edge k+LONG_CYCLES SHALL count as a short press, with no long_press.
REQ-021 In LONG, when btn=0 is sampled, the block SHALL pulse release_pulse (no short_press), clear held, and enter IDLE.
REQ-022 press_pulse, long_press and short_press SHALL each fire at most once per press.
REQ-023 No two of press_pulse, long_press and repeat_pulse SHALL be high in the same cycle.
REQ-024 The counters SHALL saturate and never wrap.

Reset
REQ-025 reset_n low SHALL asynchronously force state=IDLE, all counters=0, and every output=0.
REQ-026 reset_n low SHALL force btn_q=1, so a btn already high at reset release SHALL produce no press_pulse until btn is first seen low.
REQ-027 Reset asserted mid-press (PRESSED or LONG) SHALL discard the press and emit no release_pulse or short_press.

Configuration
REQ-028 When BUTTON_EVENT_REPEAT_EN is defined, the block SHALL pulse repeat_pulse in LONG every REPEAT_CYCLES cycles, with the first pulse REPEAT_CYCLES cycles after long_press.
REQ-029 When BUTTON_EVENT_REPEAT_EN is defined, a release SHALL stop repeats immediately, and no repeat_pulse SHALL accompany release_pulse.
REQ-030 When BUTTON_EVENT_REPEAT_EN is not defined, repeat_pulse SHALL be constant 0 and the repeat counter SHALL not be instantiated; all other behaviour SHALL be unchanged.

Verification
(Bench parameters: CLK_FREQ=1000, LONG_MS=10, REPEAT_MS=4, giving LONG_CYCLES=10 and REPEAT_CYCLES=4.)
REQ-031 Scenario: btn high 3 cycles then low -> press_pulse at cycle 1; release_pulse and short_press together on the release cycle; no long_press.
REQ-032 Scenario: btn high 25 cycles, macro defined -> long_press 10 cycles after press_pulse; held=1; repeat_pulse at +14, +18 and +22; then release_pulse only, held=0.
REQ-033 Scenario: btn falls exactly at edge k+10 -> short_press=1 and long_press never pulses.
REQ-034 Scenario: btn high during reset and held after reset_n rises -> no press_pulse; after btn goes low then high, press_pulse fires once.
REQ-035 Scenario: reset_n pulsed low at hold cycle 5 -> all outputs 0; no short_press or release_pulse follows.
REQ-036 Scenario: macro undefined, btn held 25 cycles -> repeat_pulse stays 0 throughout; long_press and held are as in the REQ-032 scenario.

Source files
------------

// File: rtl/button_event.sv
// Button event decoder: press/release/short/long pulses and a held level from a debounced button.
// Define BUTTON_EVENT_REPEAT_EN to add auto-repeat pulses while the button is long-held.
module button_event #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int LONG_MS   = 1000,
   parameter int REPEAT_MS = 200
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_press,
   output logic long_press,
   output logic repeat_pulse,
   output logic held
);

   // state   | meaning
   // IDLE    | waiting for a rising edge of btn
   // PRESSED | button down, hold counter running toward the long threshold
   // LONG    | long threshold reached, held asserted (repeat counter running if enabled)

   // 64-bit products so the default 50 MHz x 1000 ms does not overflow
   localparam longint LONG_CYCLES_L   = (longint'(CLK_FREQ) * longint'(LONG_MS)) / 64'sd1000;
   localparam longint REPEAT_CYCLES_L = (longint'(CLK_FREQ) * longint'(REPEAT_MS)) / 64'sd1000;
   localparam int     LONG_CYCLES     = int'(LONG_CYCLES_L);
   localparam int     REPEAT_CYCLES   = int'(REPEAT_CYCLES_L);
   localparam int     CW              = $clog2(LONG_CYCLES) + 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(LONG_CYCLES - 1);

   if (LONG_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_cfg_check
      $error("button_event: requires LONG_CYCLES >= 2 and REPEAT_CYCLES >= 1");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            btn_q;
   logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
   logic            press_q, press_d;
   logic            release_q, release_d;
   logic            short_q, short_d;
   logic            long_q, long_d;
   logic            held_q, held_d;

`ifdef BUTTON_EVENT_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES) + 1;
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
   logic            rep_q, rep_d;
`endif

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      short_d    = 1'b0;
      long_d     = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      rep_cnt_d  = rep_cnt_q;
      rep_d      = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (btn && !btn_q) begin
               press_d    = 1'b1;
               hold_cnt_d = '0;
               state_d    = PRESSED;
            end
         end
         PRESSED: begin
            // release is tested first so a release on the threshold edge stays short
            if (!btn) begin
               release_d = 1'b1;
               short_d   = 1'b1;
               state_d   = IDLE;
            end else if (hold_cnt_q == HOLD_LAST) begin
               long_d    = 1'b1;
               state_d   = LONG;
`ifdef BUTTON_EVENT_REPEAT_EN
               rep_cnt_d = '0;
`endif
            end else if (hold_cnt_q != '1) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         LONG: begin
            if (!btn) begin
               release_d = 1'b1;
               state_d   = IDLE;
            end
`ifdef BUTTON_EVENT_REPEAT_EN
            else if (rep_cnt_q == REP_LAST) begin
               rep_d     = 1'b1;
               rep_cnt_d = '0;
            end else if (rep_cnt_q != '1) begin
               rep_cnt_d = rep_cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      held_d = (state_d == LONG);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         btn_q      <= 1'b1;
         hold_cnt_q <= '0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         short_q    <= 1'b0;
         long_q     <= 1'b0;
         held_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         btn_q      <= btn;
         hold_cnt_q <= hold_cnt_d;
         press_q    <= press_d;
         release_q  <= release_d;
         short_q    <= short_d;
         long_q     <= long_d;
         held_q     <= held_d;
      end
   end

`ifdef BUTTON_EVENT_REPEAT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rep_cnt_q <= '0;
         rep_q     <= 1'b0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
         rep_q     <= rep_d;
      end
   end

   assign repeat_pulse = rep_q;
`else
   assign repeat_pulse = 1'b0;
`endif

   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign short_press   = short_q;
   assign long_press    = long_q;
   assign held          = held_q;

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: a duration-based reference model queues expected pulses,
// a monitor pops and compares them whenever the DUT pulses.
module tb_button_event;

   localparam int CLK_FREQ  = 1000;
   localparam int LONG_MS   = 10;
   localparam int REPEAT_MS = 4;
   localparam int L         = 10;
   localparam int R         = 4;
`ifdef BUTTON_EVENT_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic btn = 1'b0;
   logic press_pulse, release_pulse, short_press, long_press, repeat_pulse, held;

   button_event #(
      .CLK_FREQ (CLK_FREQ),
      .LONG_MS  (LONG_MS),
      .REPEAT_MS(REPEAT_MS)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .btn          (btn),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .short_press  (short_press),
      .long_press   (long_press),
      .repeat_pulse (repeat_pulse),
      .held         (held)
   );

   always #5 clk = ~clk;

   // pulse vector layout: {press, release, short, long, repeat}
   typedef struct {
      int         cyc;
      logic [4:0] vec;
   } ev_t;

   ev_t exp_q[$];
   bit  held_exp[int];
   int  checks = 0;
   int  errors = 0;
   int  edge_cnt = 0;

   // reference model: press start edge and duration arithmetic
   bit  m_active = 1'b0;
   int  m_k = 0;
   bit  m_prev = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s @edge %0d: got %0h, expected %0h", name, edge_cnt, act, req);
      end
   endtask

   function automatic void model_edge(input int c, input bit b, input bit rst);
      logic [4:0] vec;
      int d;
      vec = '0;
      if (!rst) begin
         m_active = 1'b0;
         m_prev   = 1'b1;
         held_exp[c] = 1'b0;
         return;
      end
      if (!m_active) begin
         if (b && !m_prev) begin
            m_active = 1'b1;
            m_k      = c;
            vec[4]   = 1'b1;
         end
      end else begin
         d = c - m_k;
         if (!b) begin
            vec[3]   = 1'b1;
            vec[2]   = (d <= L);
            m_active = 1'b0;
         end else if (d == L) begin
            vec[1] = 1'b1;
         end else if (REP_EN && d > L && ((d - L) % R) == 0) begin
            vec[0] = 1'b1;
         end
      end
      m_prev = b;
      held_exp[c] = m_active && ((c - m_k) >= L);
      if (vec != '0) exp_q.push_back('{cyc: c, vec: vec});
   endfunction

   task automatic drive(input bit b, input bit rst);
      @(negedge clk);
      reset_n = rst;
      btn     = b;
      model_edge(edge_cnt + 1, b, rst);
      if (!rst) begin
         #1;
         check("reset_outputs",
               {26'd0, press_pulse, release_pulse, short_press, long_press, repeat_pulse, held}, 32'd0);
      end
   endtask

   task automatic hold_level(input bit b, input int n);
      for (int i = 0; i < n; i++) drive(b, 1'b1);
   endtask

   // monitor
   initial begin
      logic [4:0] vec;
      ev_t e;
      forever begin
         @(posedge clk);
         edge_cnt++;
         #1;
         vec = {press_pulse, release_pulse, short_press, long_press, repeat_pulse};
         while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
            e = exp_q.pop_front();
            check("missing_event", 32'd0, {27'd0, e.vec});
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
            e = exp_q.pop_front();
            check("event_vec", {27'd0, vec}, {27'd0, e.vec});
         end else if (vec != '0) begin
            check("unexpected_pulse", {27'd0, vec}, 32'd0);
         end
         check("held", {31'd0, held},
               {31'd0, held_exp.exists(edge_cnt) ? held_exp[edge_cnt] : 1'b0});
         if (vec != '0)
            check("press_long_repeat_exclusive",
                  ($countones({press_pulse, long_press, repeat_pulse}) <= 1) ? 32'd1 : 32'd0, 32'd1);
      end
   end

   initial begin
      int lvl;
      int len;
      hold_level(1'b0, 0);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
      hold_level(1'b0, 2);

      // short press of 3 cycles
      hold_level(1'b1, 3);
      hold_level(1'b0, 3);
      // long hold of 25 cycles with repeats
      hold_level(1'b1, 25);
      hold_level(1'b0, 3);
      // release exactly on the threshold edge, then one past it
      hold_level(1'b1, 10);
      hold_level(1'b0, 2);
      hold_level(1'b1, 11);
      hold_level(1'b0, 2);
      // btn high through reset: no press until seen low
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
      hold_level(1'b1, 8);
      hold_level(1'b0, 1);
      hold_level(1'b1, 3);
      hold_level(1'b0, 2);
      // reset in the middle of a press and of a long hold
      hold_level(1'b1, 6);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      hold_level(1'b0, 3);
      hold_level(1'b1, 16);
      drive(1'b1, 1'b0);
      hold_level(1'b0, 3);
      // release followed immediately by a new press
      hold_level(1'b1, 2);
      hold_level(1'b0, 1);
      hold_level(1'b1, 2);
      hold_level(1'b0, 2);

      // randomized segments with occasional resets
      lvl = 0;
      for (int s = 0; s < 80; s++) begin
         if ($urandom_range(0, 14) == 0) begin
            len = $urandom_range(1, 3);
            for (int i = 0; i < len; i++) drive(1'($urandom_range(0, 1)), 1'b0);
         end
         lvl = 1 - lvl;
         len = $urandom_range(1, 30);
         hold_level(1'(lvl), len);
      end

      hold_level(1'b0, 4);
      @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
